// File: rtl/pipe_stage_buf_pkg.sv
// pipe_stage_buf_pkg: stage payload bundles and sizing helpers for the inter-stage buffers
package pipe_stage_buf_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } fd_payload_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        reg_we;
  } de_payload_t;
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] alu;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        mem_we;
    logic        mem_re;
    logic        reg_we;
  } em_payload_t;
  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        reg_we;
  } mw_payload_t;
  localparam int FD_W = $bits(fd_payload_t);
  localparam int DE_W = $bits(de_payload_t);
  localparam int EM_W = $bits(em_payload_t);
  localparam int MW_W = $bits(mw_payload_t);
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// sat_counter: performance counter that adds a variable amount per cycle and sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] cnt
);
  localparam int SW = (CNT_W > INC_W ? CNT_W : INC_W) + 1;
  logic [SW-1:0] sum;
  assign sum = SW'(cnt) + SW'(inc);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= clr ? '0 : (sum > SW'({CNT_W{1'b1}})) ? '1 : sum[CNT_W-1:0];
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic valid/ready queue between pipeline stages with stall, flush and perf counters
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int PAYLOAD_W = DE_W,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [PAYLOAD_W-1:0]      in_payload_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [PAYLOAD_W-1:0]      out_payload_o,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      clr_cnt_i,
  output logic [occ_w(DEPTH)-1:0]   occupancy_o,
  output logic [CNT_W-1:0]          bp_cnt_o,
  output logic [CNT_W-1:0]          drop_cnt_o
);
  localparam int OW = occ_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  logic [PAYLOAD_W-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [OW-1:0] occ, occ_nxt, drop_inc;
  logic push, pop, bp_hold;
  function automatic logic [PW-1:0] adv(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign push          = in_valid_i & in_ready_o & !flush_i;
  assign out_valid_o   = (occ != '0) & !stall_i;
  assign pop           = out_valid_o & out_ready_i;
  assign out_payload_o = mem[rd_ptr];
  assign occupancy_o   = occ;
  assign occ_nxt       = occ + OW'(push) - OW'(pop);
  assign bp_hold       = (occ != '0) & (stall_i | !out_ready_i) & !flush_i;
  assign drop_inc      = flush_i ? occ - OW'(pop) : '0;
  // ready is registered from the next occupancy so downstream ready never reaches upstream combinationally
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      occ        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      in_ready_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      occ        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      in_ready_o <= 1'b1;
    end else begin
      occ        <= occ_nxt;
      in_ready_o <= occ_nxt != OW'(DEPTH);
      if (push) begin
        mem[wr_ptr] <= in_payload_i;
        wr_ptr      <= adv(wr_ptr);
      end
      if (pop) rd_ptr <= adv(rd_ptr);
    end
  sat_counter #(.CNT_W(CNT_W), .INC_W(OW)) u_bp_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt_i),
    .inc (OW'(bp_hold)),
    .cnt (bp_cnt_o)
  );
  sat_counter #(.CNT_W(CNT_W), .INC_W(OW)) u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt_i),
    .inc (drop_inc),
    .cnt (drop_cnt_o)
  );
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: two buffer instances (DEPTH=2/CNT_W=16 and DEPTH=1/CNT_W=2) on shared stimulus,
// checked every cycle against a queue-based reference model
module tb_pipe_stage_buf;
  logic clk = 0, rst = 0;
  logic in_valid = 0, out_ready = 0, stall = 0, flush = 0, clr = 0;
  logic [69:0] pl = '0;
  logic rdy0, ov0, rdy1, ov1;
  logic [69:0] opl0, opl1;
  logic [1:0] occ0;
  logic [0:0] occ1;
  logic [15:0] bp0, dr0;
  logic [1:0] bp1, dr1;
  int vec = 0, err = 0;
  logic [69:0] q[2][$];
  bit rdy_m[2];
  int bp_m[2], dr_m[2], xfer[2];
  int dep[2] = '{2, 1};
  int cmax[2] = '{65535, 3};
  int n, s0, s1;
  bit ev, pp;
  logic [69:0] a_occ, a_rdy, a_ov, a_pl, a_bp, a_dr;

  always #5 clk = ~clk;

  pipe_stage_buf #(.PAYLOAD_W(70), .DEPTH(2), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy0), .in_payload_i(pl),
    .out_valid_o(ov0), .out_ready_i(out_ready), .out_payload_o(opl0), .stall_i(stall),
    .flush_i(flush), .clr_cnt_i(clr), .occupancy_o(occ0), .bp_cnt_o(bp0), .drop_cnt_o(dr0));
  pipe_stage_buf #(.PAYLOAD_W(70), .DEPTH(1), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy1), .in_payload_i(pl),
    .out_valid_o(ov1), .out_ready_i(out_ready), .out_payload_o(opl1), .stall_i(stall),
    .flush_i(flush), .clr_cnt_i(clr), .occupancy_o(occ1), .bp_cnt_o(bp1), .drop_cnt_o(dr1));

  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int smin(input int a, input int b);
    return a < b ? a : b;
  endfunction

  // Monitor and reference model: compares at the negedge, then advances the model across the next posedge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      a_occ = i == 0 ? 70'(occ0) : 70'(occ1);
      a_rdy = i == 0 ? 70'(rdy0) : 70'(rdy1);
      a_ov  = i == 0 ? 70'(ov0)  : 70'(ov1);
      a_pl  = i == 0 ? opl0 : opl1;
      a_bp  = i == 0 ? 70'(bp0)  : 70'(bp1);
      a_dr  = i == 0 ? 70'(dr0)  : 70'(dr1);
      if (!rst) begin
        chk($sformatf("rst_occ%0d", i), a_occ, 0);
        chk($sformatf("rst_ready%0d", i), a_rdy, 0);
        chk($sformatf("rst_valid%0d", i), a_ov, 0);
        chk($sformatf("rst_payload%0d", i), a_pl, 0);
        chk($sformatf("rst_bp%0d", i), a_bp, 0);
        chk($sformatf("rst_drop%0d", i), a_dr, 0);
        q[i].delete();
        rdy_m[i] = 0;
        bp_m[i] = 0;
        dr_m[i] = 0;
      end else begin
        n  = q[i].size();
        ev = n != 0 && !stall;
        pp = ev && out_ready;
        chk($sformatf("occ%0d", i), a_occ, 70'(n));
        chk($sformatf("in_ready%0d", i), a_rdy, 70'(rdy_m[i]));
        chk($sformatf("out_valid%0d", i), a_ov, 70'(ev));
        chk($sformatf("bp_cnt%0d", i), a_bp, 70'(bp_m[i]));
        chk($sformatf("drop_cnt%0d", i), a_dr, 70'(dr_m[i]));
        if (ev) chk($sformatf("payload%0d", i), a_pl, q[i][0]);
        if (pp) begin
          void'(q[i].pop_front());
          xfer[i]++;
        end
        bp_m[i] = clr ? 0 : smin(bp_m[i] + int'(n != 0 && (stall || !out_ready) && !flush), cmax[i]);
        dr_m[i] = clr ? 0 : smin(dr_m[i] + (flush ? n - int'(pp) : 0), cmax[i]);
        if (flush) q[i].delete();
        else if (in_valid && rdy_m[i]) q[i].push_back(pl);
        rdy_m[i] = flush || q[i].size() != dep[i];
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [69:0] v);
    bit acc = 0;
    in_valid = 1;
    pl = v;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = rdy0 && !flush;
      cyc();
    end
    in_valid = 0;
    pl = 'x;
    chk("send_accept", 70'(acc), 1);
  endtask

  task automatic pulse_clr();
    clr = 1;
    cyc();
    clr = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1;
    repeat (2) cyc();
    // back-to-back stream into the DEPTH=2 instance
    out_ready = 1;
    s0 = xfer[0];
    for (int v = 1; v <= 16; v++) send(70'(v));
    repeat (3) cyc();
    chk("stream_count", 70'(xfer[0] - s0), 16);
    chk("stream_bp", 70'(bp0), 0);
    // sustained throughput: one per cycle at DEPTH=2, one per two cycles at DEPTH=1
    in_valid = 1;
    repeat (3) begin
      pl = {$urandom, $urandom, $urandom};
      cyc();
    end
    s0 = xfer[0];
    s1 = xfer[1];
    repeat (20) begin
      pl = {$urandom, $urandom, $urandom};
      cyc();
    end
    chk("thru_depth2", 70'(xfer[0] - s0), 20);
    chk("thru_depth1", 70'(xfer[1] - s1), 10);
    in_valid = 0;
    repeat (3) cyc();
    // backpressure with a retried third payload
    pulse_clr();
    out_ready = 0;
    send(70'hA);
    send(70'hB);
    in_valid = 1;
    pl = 70'hC;
    repeat (4) cyc();
    chk("bp_full_ready", 70'(rdy0), 0);
    chk("bp_full_occ", 70'(occ0), 2);
    out_ready = 1;
    send(70'hC);
    repeat (4) cyc();
    // flush with two entries and a concurrent pop and push
    out_ready = 0;
    send(70'h11);
    send(70'h22);
    s0 = int'(dr0);
    out_ready = 1;
    flush = 1;
    in_valid = 1;
    pl = 70'hD;
    cyc();
    flush = 0;
    in_valid = 0;
    chk("flush_drop", 70'(int'(dr0) - s0), 1);
    chk("flush_occ", 70'(occ0), 0);
    chk("flush_ready", 70'(rdy0), 1);
    repeat (2) cyc();
    // four-cycle stall with one entry
    pulse_clr();
    stall = 1;
    send(70'h55);
    repeat (4) cyc();
    chk("stall_bp", 70'(bp0), 4);
    stall = 0;
    repeat (3) cyc();
    // DEPTH=1 counter saturates at 3
    pulse_clr();
    out_ready = 0;
    in_valid = 1;
    pl = 70'h77;
    repeat (7) cyc();
    chk("sat_bp1", 70'(bp1), 3);
    in_valid = 0;
    out_ready = 1;
    repeat (3) cyc();
    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      pl        = in_valid ? {$urandom, $urandom, $urandom} : 'x;
      out_ready = $urandom_range(0, 3) != 0;
      stall     = $urandom_range(0, 9) == 0;
      flush     = $urandom_range(0, 24) == 0;
      clr       = $urandom_range(0, 59) == 0;
      cyc();
    end
    in_valid = 0;
    stall = 0;
    flush = 0;
    clr = 0;
    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
